// File: rtl/cmsdk_ahb_pkg.sv
// Shared AHB-Lite encodings for the example master/slave interface blocks.
package cmsdk_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Tracks the second cycle of a two-cycle ERROR response.
   typedef enum logic {
      ERR_NONE,
      ERR_CANCEL
   } err_state_t;

endpackage

// File: rtl/cmsdk_ahb_eg_master_interface.sv
// AHB-Lite master bridge: valid/ready command stream in, pipelined SINGLE transfers out,
// one response pulse per command.
module cmsdk_ahb_eg_master_interface
   import cmsdk_ahb_pkg::*;
#(
   parameter int ADDRWIDTH = 32
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic                 cmd_write,
   input  logic [2:0]           cmd_size,
   input  logic [31:0]          cmd_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_write,
   output logic                 rsp_error,
   output logic [31:0]          rsp_rdata,
   output logic [ADDRWIDTH-1:0] haddrm,
   output logic [1:0]           htransm,
   output logic [2:0]           hsizem,
   output logic                 hwritem,
   output logic [2:0]           hburstm,
   output logic [3:0]           hprotm,
   output logic [31:0]          hwdatam,
   input  logic                 hreadym,
   input  logic                 hrespm,
   input  logic [31:0]          hrdatam
);

   logic                 ap_valid;
   logic [ADDRWIDTH-1:0] ap_addr;
   logic                 ap_write;
   logic [2:0]           ap_size;
   logic [31:0]          ap_wdata;
   logic                 dp_valid;
   logic                 dp_write;
   logic [31:0]          dp_wdata;

   err_state_t err_state;
   err_state_t err_next;
   logic       err1;
   logic       err2;
   logic       ap_issue;
   logic       cmd_accept;

   function automatic logic [ADDRWIDTH-1:0] align_addr(input logic [ADDRWIDTH-1:0] addr,
                                                       input logic [2:0]           size);
      logic [ADDRWIDTH-1:0] mask;
      mask = '1;
      if (size == HSIZE_HALF) mask[0] = 1'b0;
      if (size == HSIZE_WORD) mask[1:0] = 2'b00;
      return addr & mask;
   endfunction

   function automatic logic [2:0] norm_size(input logic [2:0] size);
      return (size > HSIZE_WORD) ? HSIZE_WORD : size;
   endfunction

   // Error tracker: state register
   always_ff @(posedge hclk) begin
      if (hreset) err_state <= ERR_NONE;
      else        err_state <= err_next;
   end

   // Error tracker: next state
   always_comb begin
      err1     = dp_valid & hrespm & ~hreadym;
      err_next = err1 ? ERR_CANCEL : ERR_NONE;
   end

   // Error tracker: outputs. During the cancel cycle the AP command is not presented, so it
   // must neither move to DP nor be overwritten by a new command.
   always_comb begin
      err2       = (err_state == ERR_CANCEL);
      ap_issue   = hreadym & ~err2;
      cmd_ready  = ~hreset & ~err1 & (~ap_valid | ap_issue);
      cmd_accept = cmd_valid & cmd_ready;
      htransm    = (ap_valid & ~err1 & ~err2) ? HTRANS_NONSEQ : HTRANS_IDLE;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         ap_valid  <= 1'b0;
         ap_addr   <= '0;
         ap_write  <= 1'b0;
         ap_size   <= '0;
         ap_wdata  <= '0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_wdata  <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (hreadym) begin
            dp_valid  <= ap_valid & ~err2;
            rsp_valid <= dp_valid;
            if (ap_valid & ~err2) begin
               dp_write <= ap_write;
               dp_wdata <= ap_wdata;
            end
            if (dp_valid) begin
               rsp_write <= dp_write;
               rsp_error <= hrespm;
               rsp_rdata <= dp_write ? '0 : hrdatam;
            end
         end else begin
            rsp_valid <= 1'b0;
         end

         if (cmd_accept) begin
            ap_valid <= 1'b1;
            ap_addr  <= cmd_addr;
            ap_write <= cmd_write;
            ap_size  <= norm_size(cmd_size);
            ap_wdata <= cmd_wdata;
         end else if (ap_issue) begin
            ap_valid <= 1'b0;
         end
      end
   end

   assign haddrm  = align_addr(ap_addr, ap_size);
   assign hsizem  = ap_size;
   assign hwritem = ap_write;
   assign hburstm = HBURST_SINGLE;
   assign hprotm  = HPROT_DEFAULT;
   assign hwdatam = dp_wdata;

endmodule

// File: tb/tb_cmsdk_ahb_eg_master_interface.sv
// Directed bench for the AHB-Lite master bridge; the bench plays the slave by driving
// hreadym/hrespm/hrdatam per cycle.
module tb_cmsdk_ahb_eg_master_interface;

   logic        hclk;
   logic        hreset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_write;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic [31:0] haddrm;
   logic [1:0]  htransm;
   logic [2:0]  hsizem;
   logic        hwritem;
   logic [2:0]  hburstm;
   logic [3:0]  hprotm;
   logic [31:0] hwdatam;
   logic        hreadym;
   logic        hrespm;
   logic [31:0] hrdatam;

   int checks = 0;
   int errors = 0;

   cmsdk_ahb_eg_master_interface #(.ADDRWIDTH(32)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_write (cmd_write),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_write (rsp_write),
      .rsp_error (rsp_error),
      .rsp_rdata (rsp_rdata),
      .haddrm    (haddrm),
      .htransm   (htransm),
      .hsizem    (hsizem),
      .hwritem   (hwritem),
      .hburstm   (hburstm),
      .hprotm    (hprotm),
      .hwdatam   (hwdatam),
      .hreadym   (hreadym),
      .hrespm    (hrespm),
      .hrdatam   (hrdatam)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_write = wr;
      cmd_size  = size;
      cmd_wdata = wdata;
   endtask

   // Inputs change at the falling edge; checks are taken 1ns later, mid-cycle.
   task automatic step;
      @(negedge hclk);
   endtask

   initial begin
      logic [31:0] d;
      hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
      cmd_wdata = '0; hreadym = 1'b1; hrespm = 1'b0; hrdatam = '0;

      // Reset state
      step; step; #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_htrans", 32'(htransm), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_haddr", haddrm, 0);
      chk("rst_hburst", 32'(hburstm), 0);
      chk("rst_hprot", 32'(hprotm), 32'h3);
      step; hreset = 1'b0;

      // 1: word write, zero wait states
      step; drive_cmd(32'h010, 1'b1, 3'd2, 32'hDEADBEEF); #1;
      chk("t1_cmd_ready", 32'(cmd_ready), 1);
      step; cmd_valid = 1'b0; #1;
      chk("t1_htrans", 32'(htransm), 32'h2);
      chk("t1_haddr", haddrm, 32'h010);
      chk("t1_hwrite", 32'(hwritem), 1);
      chk("t1_hsize", 32'(hsizem), 2);
      step; #1;
      chk("t1_htrans_idle", 32'(htransm), 0);
      chk("t1_hwdata", hwdatam, 32'hDEADBEEF);
      chk("t1_rsp_early", 32'(rsp_valid), 0);
      step; #1;
      chk("t1_rsp_valid", 32'(rsp_valid), 1);
      chk("t1_rsp_error", 32'(rsp_error), 0);
      chk("t1_rsp_write", 32'(rsp_write), 1);
      chk("t1_rsp_rdata", rsp_rdata, 0);
      step; #1;
      chk("t1_rsp_pulse", 32'(rsp_valid), 0);

      // 2: byte read at an odd address
      step; drive_cmd(32'h013, 1'b0, 3'd0, 32'h0);
      step; cmd_valid = 1'b0; #1;
      chk("t2_htrans", 32'(htransm), 32'h2);
      chk("t2_haddr", haddrm, 32'h013);
      chk("t2_hsize", 32'(hsizem), 0);
      chk("t2_hwrite", 32'(hwritem), 0);
      step; hrdatam = 32'hAB000000; #1;
      chk("t2_rsp_early", 32'(rsp_valid), 0);
      step; hrdatam = '0; #1;
      chk("t2_rsp_valid", 32'(rsp_valid), 1);
      chk("t2_rsp_write", 32'(rsp_write), 0);
      chk("t2_rsp_rdata", rsp_rdata, 32'hAB000000);

      // Alignment and oversize handling
      step; drive_cmd(32'h023, 1'b0, 3'd1, 32'h0);
      step; drive_cmd(32'h017, 1'b1, 3'd5, 32'h5A5A5A5A); #1;
      chk("al_half_addr", haddrm, 32'h022);
      chk("al_half_size", 32'(hsizem), 1);
      step; cmd_valid = 1'b0; hrdatam = 32'h12340000; #1;
      chk("al_word_addr", haddrm, 32'h014);
      chk("al_word_size", 32'(hsizem), 2);
      chk("al_word_trans", 32'(htransm), 32'h2);
      step; hrdatam = '0; #1;
      chk("al_rsp_rd", rsp_rdata, 32'h12340000);
      chk("al_hwdata", hwdatam, 32'h5A5A5A5A);
      step; #1;
      chk("al_rsp_wr_valid", 32'(rsp_valid), 1);
      chk("al_rsp_wr_write", 32'(rsp_write), 1);
      step; #1;
      chk("al_rsp_done", 32'(rsp_valid), 0);

      // 3: four back-to-back writes
      for (int i = 0; i < 8; i++) begin
         step;
         d = 32'(i + 1) * 32'h11;
         if (i < 4) drive_cmd(32'(4 * i), 1'b1, 3'd2, d);
         else cmd_valid = 1'b0;
         #1;
         if (i < 4) chk("t3_cmd_ready", 32'(cmd_ready), 1);
         if (i >= 1 && i <= 4) begin
            chk("t3_htrans", 32'(htransm), 32'h2);
            chk("t3_haddr", haddrm, 32'(4 * (i - 1)));
         end
         if (i >= 2 && i <= 5) chk("t3_hwdata", hwdatam, 32'(i - 1) * 32'h11);
         if (i >= 3 && i <= 6) chk("t3_rsp_on", 32'(rsp_valid), 1);
         else chk("t3_rsp_off", 32'(rsp_valid), 0);
      end

      // 4: read with two wait states, next write queued in AP
      step; drive_cmd(32'h040, 1'b0, 3'd2, 32'h0);
      step; drive_cmd(32'h044, 1'b1, 3'd2, 32'h55); #1;
      chk("t4_haddr_rd", haddrm, 32'h040);
      step; drive_cmd(32'h048, 1'b0, 3'd2, 32'h0); hreadym = 1'b0; #1;
      chk("t4_ready_w1", 32'(cmd_ready), 0);
      chk("t4_haddr_w1", haddrm, 32'h044);
      chk("t4_htrans_w1", 32'(htransm), 32'h2);
      step; #1;
      chk("t4_ready_w2", 32'(cmd_ready), 0);
      chk("t4_haddr_w2", haddrm, 32'h044);
      chk("t4_hwrite_w2", 32'(hwritem), 1);
      chk("t4_rsp_w2", 32'(rsp_valid), 0);
      step; hreadym = 1'b1; hrdatam = 32'hCAFE0001; #1;
      chk("t4_haddr_w3", haddrm, 32'h044);
      chk("t4_ready_go", 32'(cmd_ready), 1);
      step; cmd_valid = 1'b0; hrdatam = '0; #1;
      chk("t4_rsp_rd", 32'(rsp_valid), 1);
      chk("t4_rsp_rdata", rsp_rdata, 32'hCAFE0001);
      chk("t4_haddr_next", haddrm, 32'h048);
      chk("t4_hwdata", hwdatam, 32'h55);
      step; hrdatam = 32'h77; #1;
      chk("t4_rsp_wr", 32'(rsp_write), 1);
      chk("t4_rsp_wr_v", 32'(rsp_valid), 1);
      step; hrdatam = '0; #1;
      chk("t4_rsp_rd2", rsp_rdata, 32'h77);
      step; #1;
      chk("t4_rsp_done", 32'(rsp_valid), 0);

      // 5: write gets ERROR with a read waiting in AP
      step; drive_cmd(32'h080, 1'b1, 3'd2, 32'hE0);
      step; drive_cmd(32'h084, 1'b0, 3'd2, 32'h0); #1;
      chk("t5_haddr_wr", haddrm, 32'h080);
      step; cmd_valid = 1'b0; hreadym = 1'b0; hrespm = 1'b1; #1;
      chk("t5_err1_trans", 32'(htransm), 0);
      chk("t5_err1_ready", 32'(cmd_ready), 0);
      chk("t5_err1_hwdata", hwdatam, 32'hE0);
      step; hreadym = 1'b1; #1;
      chk("t5_err2_trans", 32'(htransm), 0);
      chk("t5_err2_rsp", 32'(rsp_valid), 0);
      step; hrespm = 1'b0; #1;
      chk("t5_rsp_valid", 32'(rsp_valid), 1);
      chk("t5_rsp_error", 32'(rsp_error), 1);
      chk("t5_rsp_write", 32'(rsp_write), 1);
      chk("t5_reissue", 32'(htransm), 32'h2);
      chk("t5_reissue_addr", haddrm, 32'h084);
      step; hrdatam = 32'h99; #1;
      chk("t5_rd_dp_rsp", 32'(rsp_valid), 0);
      chk("t5_rd_dp_trans", 32'(htransm), 0);
      step; hrdatam = '0; #1;
      chk("t5_rd_rsp", 32'(rsp_valid), 1);
      chk("t5_rd_err", 32'(rsp_error), 0);
      chk("t5_rd_data", rsp_rdata, 32'h99);

      // 6: reset during a waited data phase
      step; drive_cmd(32'h0A0, 1'b0, 3'd2, 32'h0);
      step; drive_cmd(32'h0A4, 1'b0, 3'd2, 32'h0);
      step; cmd_valid = 1'b0; hreadym = 1'b0;
      step; hreset = 1'b1; #1;
      chk("t6_ready_rst", 32'(cmd_ready), 0);
      step; hreadym = 1'b1; #1;
      chk("t6_trans_rst", 32'(htransm), 0);
      chk("t6_rsp_rst", 32'(rsp_valid), 0);
      chk("t6_ready_rst2", 32'(cmd_ready), 0);
      step; hreset = 1'b0; #1;
      chk("t6_ready_rel", 32'(cmd_ready), 1);
      chk("t6_trans_rel", 32'(htransm), 0);
      step; #1;
      chk("t6_rsp_rel", 32'(rsp_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
